lcd_bus_responder: RTL and testbench
====================================

# lcd_bus_responder

HD44780-compatible responder for the 8-bit parallel LCD bus (rs, rw, enable, dat) driven by our LCD writer blocks. It samples bus transactions on the falling edge of enable and decodes commands and data into a 2×COLS character buffer plus display-control state. It sits beside or instead of the physical LCD, as a mirror for VGA/UART display paths and as the checking end in bus-level simulation.

## Interface
- COLS, 16: visible characters per line; two lines total.
- clk  in  1  system clock, asynchronous to the bus enable.
- reset  in  1  synchronous, active-low.
- lcd_rs  in  1  register select: 0 command, 1 data.
- lcd_rw  in  1  1 = read transaction (ignored).
- lcd_en  in  1  bus enable; transaction latched on its falling edge.
- lcd_dat  in  8  bus data.
- rd_addr  in  $clog2(2*COLS)  buffer read index; 0..COLS-1 is line 1, COLS..2*COLS-1 is line 2.
- rd_char  out  8  character at rd_addr, registered.
- upd_valid  out  1  one-cycle pulse per stored data write.
- upd_addr  out  $clog2(2*COLS)  buffer index written.
- upd_char  out  8  character written.
- busy  out  1  clear sequence in progress.
- ac  out  7  DDRAM address counter.
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D, C, B.
- two_line  out  1  function-set N bit.
- err_busy  out  1  sticky: a transaction arrived while busy.

## Operation
- Input capture: lcd_en, lcd_rs, lcd_rw and lcd_dat each pass through a 2-flop synchronizer. A falling edge is detected on the synchronized enable (prev=1, now=0). At that cycle the synchronized rs/rw/dat are taken as the transaction.
- FSM states:
  - CLEAR: writes 0x20 to buffer index clr_idx, then increments clr_idx. After index 2*COLS-1 it goes to IDLE. busy=1 throughout.
  - IDLE: accepts transactions. Every accepted command executes in the edge cycle.
- Transaction in CLEAR: discarded, err_busy←1. err_busy clears only on reset.
- rw=1: ignored, no state change, no error.
- rs=0 commands, decoded by highest set bit:
  - 0x01: clear. AC←0, I/D←1, go to CLEAR with clr_idx=0.
  - 0x02/0x03: AC←0; buffer untouched.
  - 0x04–0x07: I/D←dat[1]; S ignored.
  - 0x08–0x0F: D,C,B←dat[2:0].
  - 0x10–0x1F: if dat[3]=0, move AC using the increment rule when dat[2]=1 and the decrement rule when dat[2]=0. If dat[3]=1 (display shift), no effect.
  - 0x20–0x3F: two_line←dat[3]; DL and F are stored internally and have no effect.
  - 0x40–0x7F: CGRAM address, no effect.
  - 0x80–0xFF: AC←dat[6:0].
  - 0x00: no effect.
- rs=1 data: if AC is visible, buffer[index(AC)]←dat and upd_valid pulses. AC then steps by I/D, whether or not AC was visible.
- Visible AC: 0x00..COLS-1 maps to index AC; 0x40..0x40+COLS-1 maps to index COLS+(AC-0x40).
- Increment rule: COLS-1→0x40; 0x40+COLS-1→0x00; otherwise AC+1 mod 128.
- Decrement rule: 0x00→0x40+COLS-1; 0x40→COLS-1; otherwise AC-1 mod 128.
- Reset values (reset low):
  - state CLEAR, clr_idx=0, busy=1.
  - ac=0, I/D=1, disp_on=cursor_on=blink_on=0, two_line=0.
  - err_busy=0, upd_valid=0, sync flops 0 (reset as enable low).
  - rd_char is not reset.
- Releasing reset starts a full clear. Reset asserted mid-clear restarts it from idx 0.

## Timing
- Enable falls at the pin in cycle t; the edge is detected at t+2; register effects (ac, flags, upd_*) are visible at t+3.
- Clear:
  - Entered by command at t+3.
  - busy=1 from t+3 for exactly 2*COLS cycles.
  - All spaces are visible to rd_char on the following read.
- Reset release: busy stays high 2*COLS cycles after the first cycle with reset=1.
- rd_char: 1-cycle latency from rd_addr. A same-cycle write to the same index returns the old value.
- Bus contract: rs/rw/dat must be stable from the enable rise until at least 3 clk after the enable fall. Enable high and low phases must each be ≥3 clk.
- An edge in the last CLEAR cycle counts as busy and is discarded.

## Structure
- Shared package lcd_pkg holds constants reused by the writer:
  - command codes 0x01/0x06/0x0C/0x38
  - LINE2_BASE=0x40
  - SPACE=0x20
  - AC width 7
- Sub-module lcd_bus_sync: 2-flop synchronizers plus enable falling-edge pulse.
- The buffer is an inferred 2*COLS×8 array with one write port (clear fill or data write) and one registered read port.

## Test plan
- Reset, then release → busy high for 32 cycles; all 32 rd_char reads return 0x20; ac=0.
- Bus sequence 38,06,0C,01, wait until busy=0, then "MENSAJE UNO" as data → indices 0..10 hold those ASCII codes; ac=0x0B; disp_on=1, cursor_on=0, two_line=1.
- Command 0x8E, then data 'A','B','C' → index 14='A', 15='B', 16='C'; ac=0x41.
- Command 0x04, command 0xC0, then data 'X','Y' → index 16='X', index 15='Y'; ac=0x0E.
- Command 0x01, then a data write 5 cycles after busy rises → write discarded; err_busy=1; index 0 still 0x20 after the clear.
- Command 0x90, then data 'Z' → no upd_valid and buffer unchanged; ac=0x11.

Source files
------------

// File: rtl/lcd_pkg.sv
// Constants and helpers shared by the LCD bus writer and responder blocks.
package lcd_pkg;
  localparam int AC_W = 7;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_FUNC  = 8'h38;

  localparam logic [AC_W-1:0] LINE2_BASE = 7'h40;
  localparam logic [7:0]      SPACE      = 8'h20;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // The address counter hops between the two visible windows rather than
  // walking through the invisible DDRAM gap between them.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] a,
                                              input logic inc,
                                              input logic [AC_W-1:0] cols);
    if (inc) begin
      if (a == cols - 7'd1) return LINE2_BASE;
      if (a == LINE2_BASE + cols - 7'd1) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return LINE2_BASE + cols - 7'd1;
    if (a == LINE2_BASE) return cols - 7'd1;
    return a - 7'd1;
  endfunction
endpackage

// File: rtl/lcd_bus_responder_if.sv
// 8-bit parallel HD44780 bus: the writer drives it, the responder listens.
interface lcd_bus_responder_if;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_dat;

   modport master (output lcd_rs, lcd_rw, lcd_en, lcd_dat);
   modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_dat);
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizers for the asynchronous LCD bus plus enable fall detect.
module lcd_bus_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rs,
   input  logic       rw,
   input  logic [7:0] dat,
   output logic       rs_s,
   output logic       rw_s,
   output logic [7:0] dat_s,
   output logic       fall
);
   logic [1:0] en_q, rs_q, rw_q;
   logic [7:0] dat_q0, dat_q1;
   logic       en_prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         en_q    <= '0;
         rs_q    <= '0;
         rw_q    <= '0;
         dat_q0  <= '0;
         dat_q1  <= '0;
         en_prev <= 1'b0;
      end else begin
         en_q    <= {en_q[0], en};
         rs_q    <= {rs_q[0], rs};
         rw_q    <= {rw_q[0], rw};
         dat_q0  <= dat;
         dat_q1  <= dat_q0;
         en_prev <= en_q[1];
      end
   end

   assign fall  = en_prev & ~en_q[1];
   assign rs_s  = rs_q[1];
   assign rw_s  = rw_q[1];
   assign dat_s = dat_q1;
endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style responder: decodes bus writes into a 2-line character buffer
// and display-control state, exposing a read port and an update stream.
module lcd_bus_responder
   import lcd_pkg::*;
#(
   parameter  int COLS = 16,
   localparam int IW   = $clog2(2*COLS)
) (
   input  logic                clk,
   input  logic                reset,
   lcd_bus_responder_if.slave  bus,
   input  logic [IW-1:0]       rd_addr,
   output logic [7:0]          rd_char,
   output logic                upd_valid,
   output logic [IW-1:0]       upd_addr,
   output logic [7:0]          upd_char,
   output logic                busy,
   output logic [AC_W-1:0]     ac,
   output logic                disp_on,
   output logic                cursor_on,
   output logic                blink_on,
   output logic                two_line,
   output logic                err_busy
);
   localparam logic [AC_W-1:0] COLS_AC = AC_W'(COLS);

   state_t        state;
   logic [IW-1:0] clr_idx;
   logic          id;
   logic          rs_s, rw_s, fall;
   logic [7:0]    dat_s;
   logic          vis_lo, vis_hi, vis, data_wr;
   logic [IW-1:0] wr_idx;
   logic [7:0]    mem [2*COLS];

   lcd_bus_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .en    (bus.lcd_en),
      .rs    (bus.lcd_rs),
      .rw    (bus.lcd_rw),
      .dat   (bus.lcd_dat),
      .rs_s  (rs_s),
      .rw_s  (rw_s),
      .dat_s (dat_s),
      .fall  (fall)
   );

   assign vis_lo  = ac < COLS_AC;
   assign vis_hi  = (ac >= LINE2_BASE) && (ac < LINE2_BASE + COLS_AC);
   assign vis     = vis_lo | vis_hi;
   assign wr_idx  = vis_lo ? ac[IW-1:0] : IW'(COLS) + IW'(ac - LINE2_BASE);
   assign data_wr = (state == ST_IDLE) && fall && !rw_s && rs_s && vis;
   assign busy    = (state == ST_CLEAR);

   // Single write port: the clear fill owns it while busy, data writes otherwise.
   always_ff @(posedge clk) begin
      if (reset && state == ST_CLEAR) mem[clr_idx] <= SPACE;
      else if (data_wr)               mem[wr_idx]  <= dat_s;
      rd_char <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_CLEAR;
         clr_idx   <= '0;
         ac        <= '0;
         id        <= 1'b1;
         disp_on   <= 1'b0;
         cursor_on <= 1'b0;
         blink_on  <= 1'b0;
         two_line  <= 1'b0;
         err_busy  <= 1'b0;
         upd_valid <= 1'b0;
         upd_addr  <= '0;
         upd_char  <= '0;
      end else begin
         upd_valid <= 1'b0;
         case (state)
            ST_CLEAR: begin
               if (fall) err_busy <= 1'b1;
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == IW'(2*COLS-1)) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (fall && !rw_s) begin
                  if (rs_s) begin
                     if (vis) begin
                        upd_valid <= 1'b1;
                        upd_addr  <= wr_idx;
                        upd_char  <= dat_s;
                     end
                     ac <= ac_step(ac, id, COLS_AC);
                  end else begin
                     casez (dat_s)
                        8'b1???????: ac <= dat_s[6:0];
                        8'b01??????: ;
                        8'b001?????: two_line <= dat_s[3];
                        8'b0001????: if (!dat_s[3]) ac <= ac_step(ac, dat_s[2], COLS_AC);
                        8'b00001???: {disp_on, cursor_on, blink_on} <= dat_s[2:0];
                        8'b000001??: id <= dat_s[1];
                        8'b0000001?: ac <= '0;
                        8'b00000001: begin
                           ac      <= '0;
                           id      <= 1'b1;
                           clr_idx <= '0;
                           state   <= ST_CLEAR;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Vector table + update scoreboard bench for lcd_bus_responder.
module tb_lcd_bus_responder;
   import lcd_pkg::*;

   typedef struct {
      logic       rs;
      logic       rw;
      logic [7:0] dat;
      logic [6:0] ac;
      logic       vis;
      logic [4:0] idx;
      logic [3:0] fl;
   } vec_t;

   typedef struct {
      logic [4:0] addr;
      logic [7:0] ch;
   } upd_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] rd_addr = '0;
   logic [7:0] rd_char;
   logic       upd_valid;
   logic [4:0] upd_addr;
   logic [7:0] upd_char;
   logic       busy;
   logic [6:0] ac;
   logic       disp_on, cursor_on, blink_on, two_line, err_busy;

   int   checks = 0;
   int   fails  = 0;
   vec_t vecs[$];
   upd_t exp_q[$];
   upd_t obs_q[$];
   logic [7:0] exp_mem [32];

   lcd_bus_responder_if bus ();

   lcd_bus_responder #(.COLS(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .rd_addr   (rd_addr),
      .rd_char   (rd_char),
      .upd_valid (upd_valid),
      .upd_addr  (upd_addr),
      .upd_char  (upd_char),
      .busy      (busy),
      .ac        (ac),
      .disp_on   (disp_on),
      .cursor_on (cursor_on),
      .blink_on  (blink_on),
      .two_line  (two_line),
      .err_busy  (err_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && upd_valid) obs_q.push_back('{addr: upd_addr, ch: upd_char});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d);
      bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_dat = d; bus.lcd_en = 1'b1;
      tick(4);
      bus.lcd_en = 1'b0;
      tick(5);
   endtask

   // Issues a clear and returns edges from enable fall to busy rise.
   task automatic clear_start(output int lat);
      bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = CMD_CLEAR; bus.lcd_en = 1'b1;
      tick(4);
      bus.lcd_en = 1'b0;
      lat = 0;
      do begin tick(1); lat++; end while (!busy && lat < 20);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 100) begin tick(1); n++; end
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         tick(1);
         chk($sformatf("%s_rd%0d", tag, i), rd_char, exp_mem[i]);
      end
   endtask

   task automatic add(input logic rs, input logic rw, input logic [7:0] d, input logic [6:0] a,
                      input logic vis, input logic [4:0] idx, input logic [3:0] fl);
      vecs.push_back('{rs: rs, rw: rw, dat: d, ac: a, vis: vis, idx: idx, fl: fl});
   endtask

   initial begin
      string msg;
      int    n, lat;
      upd_t  e, o;

      msg = "MENSAJE UNO";
      add(0,0,8'h38,7'h00,0,0,4'b0001);
      add(0,0,8'h06,7'h00,0,0,4'b0001);
      add(0,0,8'h0C,7'h00,0,0,4'b1001);
      add(0,0,8'h01,7'h00,0,0,4'b1001);
      for (int i = 0; i < 11; i++) add(1,0,msg[i],7'(i+1),1,5'(i),4'b1001);
      add(0,0,8'h8E,7'h0E,0,0,4'b1001);
      add(1,0,"A",  7'h0F,1,14,4'b1001);
      add(1,0,"B",  7'h40,1,15,4'b1001);
      add(1,0,"C",  7'h41,1,16,4'b1001);
      add(0,0,8'h04,7'h41,0,0,4'b1001);
      add(0,0,8'hC0,7'h40,0,0,4'b1001);
      add(1,0,"X",  7'h0F,1,16,4'b1001);
      add(1,0,"Y",  7'h0E,1,15,4'b1001);
      add(0,0,8'h06,7'h0E,0,0,4'b1001);
      add(0,0,8'h90,7'h10,0,0,4'b1001);
      add(1,0,"Z",  7'h11,0,0,4'b1001);
      add(0,0,8'h14,7'h12,0,0,4'b1001);
      add(0,0,8'h10,7'h11,0,0,4'b1001);
      add(0,0,8'h18,7'h11,0,0,4'b1001);
      add(0,0,8'h0F,7'h11,0,0,4'b1111);
      add(0,0,8'h40,7'h11,0,0,4'b1111);
      add(0,0,8'h00,7'h11,0,0,4'b1111);
      add(0,1,8'h01,7'h11,0,0,4'b1111);
      add(1,1,"R",  7'h11,0,0,4'b1111);
      add(0,0,8'h02,7'h00,0,0,4'b1111);
      add(0,0,8'h10,7'h4F,0,0,4'b1111);
      add(0,0,8'h14,7'h00,0,0,4'b1111);
      add(0,0,8'hCF,7'h4F,0,0,4'b1111);
      add(1,0,"Q",  7'h00,1,31,4'b1111);
      add(0,0,8'h8F,7'h0F,0,0,4'b1111);
      add(0,0,8'h14,7'h40,0,0,4'b1111);
      add(0,0,8'h30,7'h40,0,0,4'b1110);

      for (int i = 0; i < 32; i++) exp_mem[i] = SPACE;
      bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = '0;

      // Reset state and power-up clear
      tick(3);
      chk("rst_busy", busy, 1);
      chk("rst_ac", ac, 0);
      chk("rst_flags", {disp_on, cursor_on, blink_on, two_line}, 0);
      chk("rst_err", err_busy, 0);
      chk("rst_upd", upd_valid, 0);
      reset = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (busy && n < 100);
      chk("rst_busy_len", n, 32);
      check_mem("pwr");

      foreach (vecs[k]) begin
         if (!vecs[k].rs && !vecs[k].rw && vecs[k].dat == CMD_CLEAR) begin
            clear_start(lat);
            chk("clr_lat", lat, 3);
            busy_len(n);
            chk("clr_busy_len", n, 32);
            for (int i = 0; i < 32; i++) exp_mem[i] = SPACE;
         end else begin
            if (vecs[k].vis) begin
               exp_q.push_back('{addr: vecs[k].idx, ch: vecs[k].dat});
               exp_mem[vecs[k].idx] = vecs[k].dat;
            end
            bus_write(vecs[k].rs, vecs[k].rw, vecs[k].dat);
         end
         chk($sformatf("v%0d_ac", k), ac, vecs[k].ac);
         chk($sformatf("v%0d_flags", k), {disp_on, cursor_on, blink_on, two_line}, vecs[k].fl);
         chk($sformatf("v%0d_upd_cnt", k), obs_q.size(), vecs[k].vis ? 1 : 0);
         if (vecs[k].vis && obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk($sformatf("v%0d_upd_addr", k), o.addr, e.addr);
            chk($sformatf("v%0d_upd_char", k), o.ch, e.ch);
         end
         obs_q.delete();
      end
      check_mem("tbl");

      // Data write while the clear is running is dropped and flagged
      clear_start(lat);
      chk("err_clr_lat", lat, 3);
      tick(5);
      bus_write(1, 0, "K");
      chk("err_busy_mid", busy, 1);
      busy_len(n);
      chk("err_flag", err_busy, 1);
      chk("err_ac", ac, 0);
      chk("err_no_upd", obs_q.size(), 0);
      for (int i = 0; i < 32; i++) exp_mem[i] = SPACE;
      check_mem("err");

      // Reset mid-clear restarts the fill and clears the sticky error
      reset = 1'b0;
      tick(2);
      chk("rst2_err", err_busy, 0);
      chk("rst2_flags", {disp_on, cursor_on, blink_on, two_line}, 0);
      reset = 1'b1;
      tick(10);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (busy && n < 100);
      chk("rst2_busy_len", n, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
